// File: rtl/game_pkg.sv
// Shared definitions for the factorization game: state codes, result encoding
// and the small saturating/wrapping counter helpers.
package game_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'b0000,
        ST_READY    = 4'b0010,
        ST_QUESTION = 4'b0011,
        ST_INPUT    = 4'b0100,
        ST_JUDGE    = 4'b0101,
        ST_DRAW     = 4'b0110,
        ST_WRONG    = 4'b0111,
        ST_GOOD     = 4'b1000,
        ST_OUCH     = 4'b1001,
        ST_WIN      = 4'b1010,
        ST_LOSE     = 4'b1011
    } game_state_t;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_OK   = 2'b01;
    localparam logic [1:0] RES_NG   = 2'b10;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned DIGIT_W = 4;

    localparam logic [CNT_W-1:0] SCORE_MAX = CNT_W'(9);

    // Three BCD digits, most significant first
    typedef struct packed {
        logic [DIGIT_W-1:0] d3;
        logic [DIGIT_W-1:0] d2;
        logic [DIGIT_W-1:0] d1;
    } bcd3_t;

    function automatic logic [CNT_W-1:0] score_inc(input logic [CNT_W-1:0] s);
        return (s == SCORE_MAX) ? s : s + CNT_W'(1);
    endfunction

    // Round numbering skips 0 when it wraps
    function automatic logic [CNT_W-1:0] round_inc(input logic [CNT_W-1:0] r);
        return (r == '1) ? CNT_W'(1) : r + CNT_W'(1);
    endfunction

endpackage

// File: rtl/game_ctrl_hold_timer.sv
// Loadable down-counter; done_c pulses for one cycle on the last cycle of a
// load_val+1 cycle interval.
module hold_timer #(
    parameter int unsigned W = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done_c
);

    logic [W-1:0] cnt_q;
    logic         active_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (load) begin
            cnt_q    <= load_val;
            active_q <= 1'b1;
        end else if (active_q) begin
            if (cnt_q == '0) begin
                active_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - W'(1);
            end
        end
    end

    assign done_c = active_q && (cnt_q == '0);

endmodule

// File: rtl/game_ctrl.sv
// Round sequencer for the two-player factorization game: drives STATE,
// judges the decided answer, exchanges results and keeps both scores.
module game_ctrl
    import game_pkg::*;
#(
    parameter int unsigned QUESTION_CYCLES = 100,
    parameter int unsigned RESULT_CYCLES   = 100,
    parameter int unsigned INPUT_CYCLES    = 1000,
    parameter int unsigned WIN_SCORE       = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        QUE_OK,
    input  logic [23:0] QUESTION,
    input  logic        DEC,
    input  logic [3:0]  ANS3,
    input  logic [3:0]  ANS2,
    input  logic [3:0]  ANS1,
    input  logic [1:0]  OPP_RESULT,
    output logic [3:0]  STATE,
    output logic [1:0]  MY_RESULT,
    output logic        Q_REQ,
    output logic [3:0]  MY_SCORE,
    output logic [3:0]  OPP_SCORE,
    output logic [3:0]  ROUND
);

    localparam int unsigned HOLD_MAX = (QUESTION_CYCLES > RESULT_CYCLES) ? QUESTION_CYCLES
                                                                         : RESULT_CYCLES;
    localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam int unsigned IN_W     = $clog2(INPUT_CYCLES + 1);

    // Timers count load_val down to 0, so an N-cycle hold loads N-1
    localparam logic [HOLD_W-1:0] Q_LOAD  = HOLD_W'(QUESTION_CYCLES - 1);
    localparam logic [HOLD_W-1:0] R_LOAD  = HOLD_W'(RESULT_CYCLES - 1);
    localparam logic [IN_W-1:0]   IN_LOAD = IN_W'(INPUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  WIN_PTS = CNT_W'(WIN_SCORE);

    game_state_t       state_q, state_n;
    logic [1:0]        my_result_q, my_result_n;
    logic              q_req_q, q_req_n;
    logic [CNT_W-1:0]  my_score_q, my_score_n;
    logic [CNT_W-1:0]  opp_score_q, opp_score_n;
    logic [CNT_W-1:0]  round_q, round_n;
    logic              opp_ok_q, opp_ok_n;
    logic              in_expired_q, in_expired_n;

    logic              hold_load_c;
    logic [HOLD_W-1:0] hold_val_c;
    logic              hold_done_c;
    logic              in_load_c;
    logic              in_done_c;
    logic              in_timeout_c;
    logic              opp_hit_c;
    logic              answer_ok_c;
    bcd3_t             answer_c;
    bcd3_t             expect_c;
    logic              unused_question_hi;

    assign unused_question_hi = ^QUESTION[23:12];

    assign answer_c     = {ANS3, ANS2, ANS1};
    assign expect_c     = QUESTION[11:0];
    assign answer_ok_c  = (answer_c == expect_c) && (answer_c != '0);
    assign opp_hit_c    = (OPP_RESULT == RES_OK);
    // The window may run out while away in JUDGE/WRONG; remember it for INPUT
    assign in_timeout_c = in_done_c || in_expired_q;

    hold_timer #(.W(HOLD_W)) u_hold_timer (
        .CLK      (CLK),
        .RST      (RST),
        .load     (hold_load_c),
        .load_val (hold_val_c),
        .done_c   (hold_done_c)
    );

    hold_timer #(.W(IN_W)) u_input_timer (
        .CLK      (CLK),
        .RST      (RST),
        .load     (in_load_c),
        .load_val (IN_LOAD),
        .done_c   (in_done_c)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_n      = state_q;
        my_result_n  = my_result_q;
        q_req_n      = 1'b0;
        my_score_n   = my_score_q;
        opp_score_n  = opp_score_q;
        round_n      = round_q;
        opp_ok_n     = opp_ok_q;
        in_expired_n = in_expired_q || in_done_c;
        hold_load_c  = 1'b0;
        hold_val_c   = R_LOAD;
        in_load_c    = 1'b0;

        case (state_q)
            ST_IDLE, ST_WIN, ST_LOSE: begin
                if (START) begin
                    state_n     = ST_READY;
                    my_score_n  = '0;
                    opp_score_n = '0;
                    round_n     = CNT_W'(1);
                    q_req_n     = 1'b1;
                    my_result_n = RES_NONE;
                end
            end
            ST_READY: begin
                if (QUE_OK) begin
                    state_n     = ST_QUESTION;
                    hold_load_c = 1'b1;
                    hold_val_c  = Q_LOAD;
                end
            end
            ST_QUESTION: begin
                if (hold_done_c) begin
                    state_n      = ST_INPUT;
                    in_load_c    = 1'b1;
                    in_expired_n = 1'b0;
                    opp_ok_n     = 1'b0;
                end
            end
            ST_INPUT: begin
                if (DEC) begin
                    state_n = ST_JUDGE;
                    if (opp_hit_c) begin
                        opp_ok_n = 1'b1;
                    end
                end else if (opp_hit_c) begin
                    state_n     = ST_OUCH;
                    opp_score_n = score_inc(opp_score_q);
                    hold_load_c = 1'b1;
                end else if (in_timeout_c) begin
                    state_n     = ST_DRAW;
                    hold_load_c = 1'b1;
                end
            end
            ST_JUDGE: begin
                hold_load_c = 1'b1;
                if (opp_hit_c) begin
                    opp_ok_n = 1'b1;
                end
                if (answer_ok_c && (opp_ok_q || opp_hit_c)) begin
                    state_n     = ST_DRAW;
                    my_result_n = RES_OK;
                end else if (answer_ok_c) begin
                    state_n     = ST_GOOD;
                    my_score_n  = score_inc(my_score_q);
                    my_result_n = RES_OK;
                end else begin
                    state_n     = ST_WRONG;
                    my_result_n = RES_NG;
                end
            end
            ST_WRONG: begin
                if (opp_hit_c) begin
                    state_n     = ST_OUCH;
                    opp_score_n = score_inc(opp_score_q);
                    hold_load_c = 1'b1;
                    my_result_n = RES_NONE;
                end else if (hold_done_c) begin
                    state_n     = ST_INPUT;
                    my_result_n = RES_NONE;
                end
            end
            ST_GOOD, ST_OUCH, ST_DRAW: begin
                if (hold_done_c) begin
                    my_result_n = RES_NONE;
                    if (my_score_q == WIN_PTS) begin
                        state_n = ST_WIN;
                    end else if (opp_score_q == WIN_PTS) begin
                        state_n = ST_LOSE;
                    end else begin
                        state_n = ST_READY;
                        round_n = round_inc(round_q);
                        q_req_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n     = ST_IDLE;
                my_result_n = RES_NONE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            my_result_q  <= RES_NONE;
            q_req_q      <= 1'b0;
            my_score_q   <= '0;
            opp_score_q  <= '0;
            round_q      <= '0;
            opp_ok_q     <= 1'b0;
            in_expired_q <= 1'b0;
        end else begin
            state_q      <= state_n;
            my_result_q  <= my_result_n;
            q_req_q      <= q_req_n;
            my_score_q   <= my_score_n;
            opp_score_q  <= opp_score_n;
            round_q      <= round_n;
            opp_ok_q     <= opp_ok_n;
            in_expired_q <= in_expired_n;
        end
    end

    assign STATE     = state_q;
    assign MY_RESULT = my_result_q;
    assign Q_REQ     = q_req_q;
    assign MY_SCORE  = my_score_q;
    assign OPP_SCORE = opp_score_q;
    assign ROUND     = round_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: judge vector table, directed multi-cycle sequences and
// random rounds checked against a round-level score/round model.
module tb_game_ctrl;
    import game_pkg::*;

    localparam int QC = 100;
    localparam int RC = 100;
    localparam int IC = 1000;
    localparam int WS = 3;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_READY    = 4'd2;
    localparam logic [3:0] S_QUESTION = 4'd3;
    localparam logic [3:0] S_INPUT    = 4'd4;
    localparam logic [3:0] S_JUDGE    = 4'd5;
    localparam logic [3:0] S_DRAW     = 4'd6;
    localparam logic [3:0] S_WRONG    = 4'd7;
    localparam logic [3:0] S_GOOD     = 4'd8;
    localparam logic [3:0] S_OUCH     = 4'd9;
    localparam logic [3:0] S_WIN      = 4'd10;
    localparam logic [3:0] S_LOSE     = 4'd11;

    logic        CLK;
    logic        RST;
    logic        START;
    logic        QUE_OK;
    logic [23:0] QUESTION;
    logic        DEC;
    logic [3:0]  ANS3, ANS2, ANS1;
    logic [1:0]  OPP_RESULT;
    logic [3:0]  STATE;
    logic [1:0]  MY_RESULT;
    logic        Q_REQ;
    logic [3:0]  MY_SCORE, OPP_SCORE, ROUND;

    int errors = 0;
    int checks = 0;

    // Round-level model of the game
    int m_my, m_opp, m_round;
    bit m_over;

    game_ctrl #(
        .QUESTION_CYCLES (QC),
        .RESULT_CYCLES   (RC),
        .INPUT_CYCLES    (IC),
        .WIN_SCORE       (WS)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .START      (START),
        .QUE_OK     (QUE_OK),
        .QUESTION   (QUESTION),
        .DEC        (DEC),
        .ANS3       (ANS3),
        .ANS2       (ANS2),
        .ANS1       (ANS1),
        .OPP_RESULT (OPP_RESULT),
        .STATE      (STATE),
        .MY_RESULT  (MY_RESULT),
        .Q_REQ      (Q_REQ),
        .MY_SCORE   (MY_SCORE),
        .OPP_SCORE  (OPP_SCORE),
        .ROUND      (ROUND)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [11:0] q;
        logic [11:0] a;
        logic [1:0]  opp;
        logic [3:0]  st;
        logic [1:0]  res;
        int          my;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic count_in(input logic [3:0] code, input int limit, output int n);
        n = 0;
        while (STATE == code && n < limit) begin
            n++;
            tick();
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    task automatic start_game();
        START = 1'b1;
        tick();
        START = 1'b0;
        m_my = 0; m_opp = 0; m_round = 1; m_over = 1'b0;
        chk("start_state", int'(STATE), int'(S_READY));
        chk("start_qreq", int'(Q_REQ), 1);
        chk("start_round", int'(ROUND), 1);
        chk("start_my", int'(MY_SCORE), 0);
        chk("start_opp", int'(OPP_SCORE), 0);
    endtask

    task automatic enter_input(input logic [11:0] q, input bit press_start);
        int n;
        QUESTION = {12'($urandom), q};
        QUE_OK = 1'b1;
        tick();
        QUE_OK = 1'b0;
        START = press_start;
        chk("question_entry", int'(STATE), int'(S_QUESTION));
        chk("qreq_pulse_end", int'(Q_REQ), 0);
        count_in(S_QUESTION, 300, n);
        START = 1'b0;
        chk("question_len", n, QC);
        chk("input_entry", int'(STATE), int'(S_INPUT));
    endtask

    task automatic decide(input logic [11:0] a, input logic [1:0] opp);
        ANS3 = a[11:8]; ANS2 = a[7:4]; ANS1 = a[3:0];
        DEC = 1'b1;
        OPP_RESULT = opp;
        tick();
        DEC = 1'b0;
        OPP_RESULT = 2'b00;
        chk("judge_entry", int'(STATE), int'(S_JUDGE));
        tick();
    endtask

    function automatic logic [3:0] judge_exp(input logic [11:0] q, input logic [11:0] a,
                                             input bit opp_seen);
        bit ok;
        ok = (a == q) && (q != 12'h000);
        if (!ok) return S_WRONG;
        return opp_seen ? S_DRAW : S_GOOD;
    endfunction

    task automatic finish_round(input logic [3:0] exp_st, input logic [1:0] exp_res);
        int n;
        if (exp_st == S_GOOD) m_my  = (m_my  < 9) ? m_my  + 1 : 9;
        if (exp_st == S_OUCH) m_opp = (m_opp < 9) ? m_opp + 1 : 9;
        chk("result_state", int'(STATE), int'(exp_st));
        chk("result_my_result", int'(MY_RESULT), int'(exp_res));
        chk("result_my_score", int'(MY_SCORE), m_my);
        chk("result_opp_score", int'(OPP_SCORE), m_opp);
        count_in(exp_st, 300, n);
        chk("result_len", n, RC);
        if (m_my == WS) begin
            m_over = 1'b1;
            chk("end_state", int'(STATE), int'(S_WIN));
        end else if (m_opp == WS) begin
            m_over = 1'b1;
            chk("end_state", int'(STATE), int'(S_LOSE));
        end else begin
            m_round = (m_round == 15) ? 1 : m_round + 1;
            chk("next_state", int'(STATE), int'(S_READY));
            chk("next_qreq", int'(Q_REQ), 1);
        end
        chk("next_round", int'(ROUND), m_round);
        chk("next_my_result", int'(MY_RESULT), 0);
    endtask

    // One round of a scenario: 0 correct, 1 wrong then correct, 2 opponent
    // first, 3 correct together with opponent, 4 timeout
    task automatic run_round(input int sc, input int d, input logic [11:0] q,
                             input logic [11:0] aw);
        int n;
        logic [3:0] st;
        enter_input(q, 1'b0);
        case (sc)
            0, 1: begin
                repeat (d) tick();
                if (sc == 0) begin
                    decide(q, 2'b00);
                    st = judge_exp(q, q, 1'b0);
                end else begin
                    decide(aw, 2'b00);
                    st = judge_exp(q, aw, 1'b0);
                end
                if (st == S_WRONG) begin
                    chk("wrong_state", int'(STATE), int'(S_WRONG));
                    chk("wrong_my_result", int'(MY_RESULT), 2);
                    count_in(S_WRONG, 300, n);
                    chk("wrong_len", n, RC);
                    chk("retry_input", int'(STATE), int'(S_INPUT));
                    decide(q, 2'b00);
                    st = judge_exp(q, q, 1'b0);
                end
                finish_round(st, 2'b01);
            end
            2: begin
                repeat (d) tick();
                OPP_RESULT = 2'b01;
                tick();
                OPP_RESULT = 2'b00;
                finish_round(S_OUCH, 2'b00);
            end
            3: begin
                repeat (d) tick();
                decide(q, 2'b01);
                finish_round(judge_exp(q, q, 1'b1), 2'b01);
            end
            default: begin
                count_in(S_INPUT, 1200, n);
                chk("input_window_len", n, IC);
                finish_round(S_DRAW, 2'b00);
            end
        endcase
    endtask

    function automatic logic [11:0] rand_q();
        return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(1, 9))};
    endfunction

    initial begin
        int n;
        int sc;
        int d;
        logic [11:0] q;
        logic [11:0] aw;

        vecs[0] = '{12'h235, 12'h235, 2'b00, S_GOOD,  2'b01, 1};
        vecs[1] = '{12'h235, 12'h237, 2'b00, S_WRONG, 2'b10, 0};
        vecs[2] = '{12'h235, 12'h235, 2'b01, S_DRAW,  2'b01, 0};
        vecs[3] = '{12'h000, 12'h000, 2'b00, S_WRONG, 2'b10, 0};
        vecs[4] = '{12'h235, 12'h237, 2'b01, S_WRONG, 2'b10, 0};
        vecs[5] = '{12'h999, 12'h999, 2'b11, S_GOOD,  2'b01, 1};
        vecs[6] = '{12'h235, 12'h532, 2'b10, S_WRONG, 2'b10, 0};
        vecs[7] = '{12'h100, 12'h100, 2'b00, S_GOOD,  2'b01, 1};
        vecs[8] = '{12'h001, 12'h001, 2'b01, S_DRAW,  2'b01, 0};

        RST = 1'b1; START = 1'b0; QUE_OK = 1'b0; QUESTION = '0; DEC = 1'b0;
        ANS3 = '0; ANS2 = '0; ANS1 = '0; OPP_RESULT = 2'b00;
        tick();
        tick();
        chk("rst_state", int'(STATE), 0);
        chk("rst_my_result", int'(MY_RESULT), 0);
        chk("rst_qreq", int'(Q_REQ), 0);
        chk("rst_my", int'(MY_SCORE), 0);
        chk("rst_opp", int'(OPP_SCORE), 0);
        chk("rst_round", int'(ROUND), 0);
        RST = 1'b0;
        tick();
        chk("idle_hold", int'(STATE), int'(S_IDLE));

        // Judge outcome table
        for (int i = 0; i < 9; i++) begin
            do_reset();
            start_game();
            enter_input(vecs[i].q, 1'b0);
            decide(vecs[i].a, vecs[i].opp);
            chk("vec_state", int'(STATE), int'(vecs[i].st));
            chk("vec_my_result", int'(MY_RESULT), int'(vecs[i].res));
            chk("vec_my_score", int'(MY_SCORE), vecs[i].my);
            chk("vec_opp_score", int'(OPP_SCORE), 0);
        end

        // Basic win round, then wrong answer with retry (START ignored mid-round)
        do_reset();
        start_game();
        enter_input(12'h235, 1'b0);
        decide(12'h235, 2'b00);
        finish_round(S_GOOD, 2'b01);
        enter_input(12'h235, 1'b1);
        decide(12'h237, 2'b00);
        chk("retry_wrong_state", int'(STATE), int'(S_WRONG));
        chk("retry_wrong_res", int'(MY_RESULT), 2);
        count_in(S_WRONG, 300, n);
        chk("retry_wrong_len", n, RC);
        chk("retry_back_input", int'(STATE), int'(S_INPUT));
        decide(12'h235, 2'b00);
        finish_round(S_GOOD, 2'b01);

        // Opponent first, then plain timeout
        enter_input(12'h235, 1'b0);
        repeat (10) tick();
        OPP_RESULT = 2'b01;
        tick();
        OPP_RESULT = 2'b00;
        finish_round(S_OUCH, 2'b00);
        run_round(4, 0, 12'h481, 12'h000);

        // Window expires while in WRONG: one INPUT cycle, then DRAW
        enter_input(12'h235, 1'b0);
        repeat (950) tick();
        decide(12'h111, 2'b00);
        chk("late_wrong_state", int'(STATE), int'(S_WRONG));
        count_in(S_WRONG, 300, n);
        chk("late_wrong_len", n, RC);
        count_in(S_INPUT, 50, n);
        chk("late_input_len", n, 1);
        finish_round(S_DRAW, 2'b00);

        // DEC on the last window cycle beats the timeout; third point wins
        enter_input(12'h235, 1'b0);
        repeat (IC - 1) tick();
        decide(12'h235, 2'b00);
        finish_round(S_GOOD, 2'b01);
        chk("game_won", int'(m_over), 1);
        start_game();

        // Opponent scores while we sit in WRONG
        enter_input(12'h642, 1'b0);
        decide(12'h643, 2'b00);
        chk("wrong_opp_state", int'(STATE), int'(S_WRONG));
        repeat (20) tick();
        OPP_RESULT = 2'b01;
        tick();
        OPP_RESULT = 2'b00;
        finish_round(S_OUCH, 2'b00);

        // Round counter wraps 15 -> 1 across shared-answer draws
        for (int i = 0; i < 15; i++) begin
            run_round(3, 0, 12'h357, 12'h000);
        end

        // Reset mid-round
        enter_input(12'h235, 1'b0);
        repeat (5) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("midrst_state", int'(STATE), 0);
        chk("midrst_my_result", int'(MY_RESULT), 0);
        chk("midrst_qreq", int'(Q_REQ), 0);
        chk("midrst_my", int'(MY_SCORE), 0);
        chk("midrst_opp", int'(OPP_SCORE), 0);
        chk("midrst_round", int'(ROUND), 0);

        // READY waits for QUE_OK; an illegal code falls back to IDLE
        start_game();
        repeat (5) tick();
        chk("ready_wait", int'(STATE), int'(S_READY));
        force dut.state_q = game_state_t'(4'hF);
        #1;
        release dut.state_q;
        tick();
        chk("illegal_to_idle", int'(STATE), int'(S_IDLE));

        // Randomized rounds against the model
        do_reset();
        start_game();
        for (int r = 0; r < 30; r++) begin
            if (m_over) start_game();
            sc = int'($urandom_range(0, 4));
            d  = (sc == 1) ? int'($urandom_range(0, 600)) : int'($urandom_range(0, IC - 1));
            q  = rand_q();
            aw = rand_q();
            if (aw == q) aw[3:0] = (q[3:0] == 4'd9) ? 4'd1 : q[3:0] + 4'd1;
            run_round(sc, d, q, aw);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
